// File: rtl/fifo_v2.sv
// fifo_v2: parametrised single-clock FIFO with selectable standard or
// first-word-fall-through read mode, exact occupancy count, run-time
// programmable almost-full/almost-empty thresholds and sticky
// overflow/underflow flags.
module fifo_v2 #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int FWFT  = 0,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             re,
    output logic [WIDTH-1:0] dout,
    output logic             val,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    input  logic [CNT_W-1:0] h_pos,
    input  logic [CNT_W-1:0] l_pos,
    output logic             p_full,
    output logic             p_empty,
    output logic             ovf,
    output logic             udf,
    input  logic             clr_err
);

    localparam int ADDR_W = $clog2(DEPTH);

    // Storage array (no reset: contents are only meaningful behind the pointers)
    logic [WIDTH-1:0]  mem_q [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic              full_q;
    logic              empty_q;
    logic              p_full_q;
    logic              p_empty_q;
    logic              val_q,    val_d;
    logic [WIDTH-1:0]  dout_q,   dout_d;
    logic              ovf_q,    ovf_d;
    logic              udf_q,    udf_d;

    logic              wr_ok;
    logic              rd_ok;
    logic              mem_we;
    logic              mem_re;
    logic              head_last;
    logic              bypass;

    // Accept decisions use the registered full/empty flags from before the edge
    always_comb begin
        wr_ok = we & ~full_q;
        rd_ok = re & ~empty_q;
    end

    // Occupancy: moves only on accepted operations, simultaneous ops cancel
    always_comb begin
        count_d = count_q;
        if (wr_ok && !rd_ok) begin
            count_d = count_q + 1'b1;
        end else if (rd_ok && !wr_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    // Read datapath and array access control for the selected read mode.
    // In FWFT mode the head word lives in dout_q and counts toward count_q,
    // so the array holds count_q-1 words; a write goes straight into the head
    // register when the FIFO is empty or when the only word is being popped.
    always_comb begin
        head_last = 1'b0;
        bypass    = 1'b0;
        mem_we    = wr_ok;
        mem_re    = rd_ok;
        val_d     = rd_ok;
        dout_d    = dout_q;
        if (FWFT != 0) begin
            head_last = (count_q == CNT_W'(1));
            bypass    = wr_ok & (~val_q | (rd_ok & head_last));
            mem_we    = wr_ok & ~bypass;
            mem_re    = rd_ok & ~head_last;
            val_d     = val_q;
            if (bypass) begin
                dout_d = din;
                val_d  = 1'b1;
            end else if (mem_re) begin
                dout_d = mem_q[rd_ptr_q];
                val_d  = 1'b1;
            end else if (rd_ok) begin
                val_d  = 1'b0;
            end
        end else begin
            if (rd_ok) begin
                dout_d = mem_q[rd_ptr_q];
            end
        end
    end

    // Pointer advance; ADDR_W-bit pointers wrap naturally at DEPTH-1
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (mem_we) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (mem_re) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Sticky error flags: a new error in the clearing cycle keeps the flag set
    always_comb begin
        ovf_d = (we & full_q)  | (ovf_q & ~clr_err);
        udf_d = (re & empty_q) | (udf_q & ~clr_err);
    end

    // Control and status registers, status flags derived from the next count
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            p_full_q  <= 1'b0;
            p_empty_q <= 1'b1;
            val_q     <= 1'b0;
            dout_q    <= '0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            full_q    <= (count_d == CNT_W'(DEPTH));
            empty_q   <= (count_d == '0);
            p_full_q  <= (count_d >= h_pos);
            p_empty_q <= (count_d <= l_pos);
            val_q     <= val_d;
            dout_q    <= dout_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
        end
    end

    // Array write port
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign full    = full_q;
    assign empty   = empty_q;
    assign count   = count_q;
    assign p_full  = p_full_q;
    assign p_empty = p_empty_q;
    assign val     = val_q;
    assign dout    = dout_q;
    assign ovf     = ovf_q;
    assign udf     = udf_q;

endmodule

// File: tb/tb_fifo_v2.sv
// tb_fifo_v2: directed bench driving a standard-read and an FWFT instance
// of fifo_v2 from the same inputs; occupancy and flags must agree, read data
// is checked per mode against hand-computed values.
module tb_fifo_v2;

    logic       clk;
    logic       rst;
    logic       we;
    logic       re;
    logic       clr_err;
    logic [7:0] din;
    logic [4:0] h_pos;
    logic [4:0] l_pos;

    logic       full_s, empty_s, val_s, p_full_s, p_empty_s, ovf_s, udf_s;
    logic [7:0] dout_s;
    logic [4:0] count_s;
    logic       full_f, empty_f, val_f, p_full_f, p_empty_f, ovf_f, udf_f;
    logic [7:0] dout_f;
    logic [4:0] count_f;

    int n_cmp = 0;
    int n_bad = 0;

    fifo_v2 #(.WIDTH(8), .DEPTH(16), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .we(we), .din(din), .full(full_s), .re(re),
        .dout(dout_s), .val(val_s), .empty(empty_s), .count(count_s),
        .h_pos(h_pos), .l_pos(l_pos), .p_full(p_full_s), .p_empty(p_empty_s),
        .ovf(ovf_s), .udf(udf_s), .clr_err(clr_err)
    );

    fifo_v2 #(.WIDTH(8), .DEPTH(16), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .we(we), .din(din), .full(full_f), .re(re),
        .dout(dout_f), .val(val_f), .empty(empty_f), .count(count_f),
        .h_pos(h_pos), .l_pos(l_pos), .p_full(p_full_f), .p_empty(p_empty_f),
        .ovf(ovf_f), .udf(udf_f), .clr_err(clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Both instances must agree on everything except read data timing
    task automatic chk_both(input string tag, input logic [4:0] cnt, input logic e,
                            input logic f, input logic pe, input logic pf,
                            input logic o, input logic u);
        chk({tag, " count_s"}, 32'(count_s), 32'(cnt));
        chk({tag, " count_f"}, 32'(count_f), 32'(cnt));
        chk({tag, " empty_s"}, 32'(empty_s), 32'(e));
        chk({tag, " empty_f"}, 32'(empty_f), 32'(e));
        chk({tag, " full_s"}, 32'(full_s), 32'(f));
        chk({tag, " full_f"}, 32'(full_f), 32'(f));
        chk({tag, " p_empty_s"}, 32'(p_empty_s), 32'(pe));
        chk({tag, " p_empty_f"}, 32'(p_empty_f), 32'(pe));
        chk({tag, " p_full_s"}, 32'(p_full_s), 32'(pf));
        chk({tag, " p_full_f"}, 32'(p_full_f), 32'(pf));
        chk({tag, " ovf_s"}, 32'(ovf_s), 32'(o));
        chk({tag, " ovf_f"}, 32'(ovf_f), 32'(o));
        chk({tag, " udf_s"}, 32'(udf_s), 32'(u));
        chk({tag, " udf_f"}, 32'(udf_f), 32'(u));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Streaming sequence: three prefilled words then 0x60, 0x61, ...
    function automatic logic [7:0] sw(input int j);
        if (j < 3) return 8'(8'h5C + j);
        return 8'(8'h60 + j - 3);
    endfunction

    initial begin
        rst = 1'b1; we = 1'b0; re = 1'b0; clr_err = 1'b0; din = '0;
        h_pos = 5'd12; l_pos = 5'd3;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk_both("reset", 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("reset val_s", 32'(val_s), 32'd0);
        chk("reset val_f", 32'(val_f), 32'd0);
        chk("reset dout_s", 32'(dout_s), 32'd0);
        chk("reset dout_f", 32'(dout_f), 32'd0);

        // Fill 0x00..0x0F, watching thresholds h_pos=12 / l_pos=3
        for (int i = 0; i < 16; i++) begin
            we = 1'b1; din = 8'(i);
            tick();
            chk("fill count", 32'(count_s), 32'(i + 1));
            chk("fill count_f", 32'(count_f), 32'(i + 1));
            chk("fill p_empty", 32'(p_empty_s), 32'((i + 1) <= 3));
            chk("fill p_full", 32'(p_full_f), 32'((i + 1) >= 12));
            chk("fill full", 32'(full_s), 32'(i == 15));
            chk("fill val_s", 32'(val_s), 32'd0);
            chk("fill val_f", 32'(val_f), 32'd1);
            chk("fill dout_f", 32'(dout_f), 32'h00);
        end

        // Write while full is dropped and sets ovf
        we = 1'b1; din = 8'hAA;
        tick();
        chk_both("ovf set", 5'd16, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        we = 1'b0; clr_err = 1'b1;
        tick();
        chk_both("ovf clr", 5'd16, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        // Set and clear in the same cycle: set wins
        we = 1'b1; clr_err = 1'b1;
        tick();
        chk("ovf set wins s", 32'(ovf_s), 32'd1);
        chk("ovf set wins f", 32'(ovf_f), 32'd1);
        we = 1'b0; clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("ovf clr2", 32'(ovf_s), 32'd0);

        // Drain 16 words back-to-back
        for (int k = 0; k < 16; k++) begin
            re = 1'b1;
            tick();
            chk("drain count", 32'(count_s), 32'(15 - k));
            chk("drain dout_s", 32'(dout_s), 32'(k));
            chk("drain val_s", 32'(val_s), 32'd1);
            chk("drain val_f", 32'(val_f), 32'(k < 15));
            if (k < 15) chk("drain dout_f", 32'(dout_f), 32'(k + 1));
        end
        chk_both("drained", 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        re = 1'b0;
        tick();
        chk("idle val_s", 32'(val_s), 32'd0);
        chk("hold dout_s", 32'(dout_s), 32'h0F);

        // Read while empty sets udf
        re = 1'b1;
        tick();
        chk_both("udf set", 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("udf val_s", 32'(val_s), 32'd0);
        chk("udf val_f", 32'(val_f), 32'd0);
        re = 1'b0; clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("udf clr", 32'(udf_f), 32'd0);

        // Simultaneous write/read when empty: write taken, read dropped
        we = 1'b1; re = 1'b1; din = 8'h33;
        tick();
        chk_both("wr+rd empty", 5'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("wr+rd empty val_s", 32'(val_s), 32'd0);
        chk("wr+rd empty val_f", 32'(val_f), 32'd1);
        chk("wr+rd empty dout_f", 32'(dout_f), 32'h33);
        we = 1'b0; re = 1'b0; clr_err = 1'b1;
        tick();
        clr_err = 1'b0;

        // Simultaneous write/read with count=1
        we = 1'b1; re = 1'b1; din = 8'h44;
        tick();
        chk_both("wr+rd one", 5'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("wr+rd one dout_s", 32'(dout_s), 32'h33);
        chk("wr+rd one val_s", 32'(val_s), 32'd1);
        chk("wr+rd one dout_f", 32'(dout_f), 32'h44);
        chk("wr+rd one val_f", 32'(val_f), 32'd1);
        we = 1'b0; re = 1'b1;
        tick();
        chk("pop last dout_s", 32'(dout_s), 32'h44);
        chk("pop last val_f", 32'(val_f), 32'd0);
        chk("pop last count", 32'(count_f), 32'd0);

        // FWFT bypass: single write to empty is visible after one edge
        re = 1'b0; we = 1'b1; din = 8'h5C;
        tick();
        chk("bypass val_f", 32'(val_f), 32'd1);
        chk("bypass dout_f", 32'(dout_f), 32'h5C);
        chk("bypass val_s", 32'(val_s), 32'd0);
        din = 8'h5D;
        tick();
        din = 8'h5E;
        tick();
        chk("prefill count", 32'(count_s), 32'd3);
        chk("prefill head", 32'(dout_f), 32'h5C);

        // Streaming we=re=1 for 20 cycles: count constant, data in order
        for (int i = 0; i < 20; i++) begin
            we = 1'b1; re = 1'b1; din = 8'(8'h60 + i);
            tick();
            chk("stream count_s", 32'(count_s), 32'd3);
            chk("stream count_f", 32'(count_f), 32'd3);
            chk("stream dout_s", 32'(dout_s), 32'(sw(i)));
            chk("stream val_s", 32'(val_s), 32'd1);
            chk("stream dout_f", 32'(dout_f), 32'(sw(i + 1)));
            chk("stream val_f", 32'(val_f), 32'd1);
        end

        // Grow to count=9, then reset mid-stream
        for (int i = 0; i < 6; i++) begin
            we = 1'b1; re = 1'b0; din = 8'(8'h80 + i);
            tick();
        end
        we = 1'b0;
        chk("pre-rst count", 32'(count_s), 32'd9);
        chk("pre-rst head", 32'(dout_f), 32'h71);
        rst = 1'b1; we = 1'b1; din = 8'hEE;
        tick();
        rst = 1'b0; we = 1'b0;
        chk_both("mid rst", 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("mid rst val_s", 32'(val_s), 32'd0);
        chk("mid rst val_f", 32'(val_f), 32'd0);
        chk("mid rst dout_f", 32'(dout_f), 32'd0);

        // Fresh data after reset; threshold change lags by one cycle
        we = 1'b1; din = 8'hC3; h_pos = 5'd1;
        tick();
        we = 1'b0;
        chk("post-rst dout_f", 32'(dout_f), 32'hC3);
        chk("post-rst p_full", 32'(p_full_s), 32'd1);
        h_pos = 5'd2;
        tick();
        chk("thr lag p_full", 32'(p_full_s), 32'd0);
        re = 1'b1;
        tick();
        re = 1'b0;
        chk("post-rst dout_s", 32'(dout_s), 32'hC3);
        chk("post-rst val_s", 32'(val_s), 32'd1);
        chk_both("post-rst drain", 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
